// File: rtl/dst4_mac_sched.sv
`default_nettype none
// ============================================================================
// Module      : dst4_mac_sched
// Description : Sequencer for an external combinational 4-tap signed MAC in
//               the 4x4 DST-VII datapath. Accepts one 4-sample block. Then
//               runs the MAC once per matrix row (or per column for the
//               inverse). Streams the four coefficients out one per beat.
//               Ports:
//                 clk, rst                  clock / sync active-high reset
//                 in_valid/in_ready         block handshake
//                 in_x, in_inv              samples, inverse select
//                 mac_x, mac_c, mac_y       operands to / result from MAC
//                 out_valid/out_ready       result-beat handshake
//                 out_y, out_idx, out_last  coefficient, index k, k==3 flag
//                 busy                      high while a block is in flight
// Revision    : 1.0 - initial release
// ============================================================================
module dst4_mac_sched #(
    parameter int IN_W    = 12,
    parameter int COEFF_W = 8,
    parameter int OUT_W   = IN_W + COEFF_W + 2,
    parameter int SHIFT   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*IN_W-1:0]    in_x,
    input  logic                 in_inv,
    output logic [4*IN_W-1:0]    mac_x,
    output logic [4*COEFF_W-1:0] mac_c,
    input  logic [OUT_W-1:0]     mac_y,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_y,
    output logic [1:0]           out_idx,
    output logic                 out_last,
    output logic                 busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // DST-VII matrix, row-major: entry (row, col) lives at index {row, col}.
    localparam int c_rom [16] = '{ 29,  55,  74,  84,
                                   74,  74,   0, -74,
                                   84, -29, -74,  55,
                                   55, -84,  74, -29 };

    state_t              state_q, state_d;
    logic [1:0]          k_q, k_d;
    logic [4*IN_W-1:0]   x_q, x_d;
    logic                inv_q, inv_d;
    logic [OUT_W-1:0]    y_q, y_d;
    logic                valid_q, valid_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                last_q, last_d;
    logic [OUT_W-1:0]    w_round;

    // Operands are only presented during CALC so the MAC inputs stay quiet
    // the rest of the time.
    assign mac_x = (state_q == ST_CALC) ? x_q : '0;

    generate
        for (genvar n = 0; n < 4; n++) begin : g_col
            logic [1:0] w_row;
            logic [1:0] w_col;
            // The inverse uses the transpose, so row and column swap roles.
            assign w_row = inv_q ? 2'(n) : k_q;
            assign w_col = inv_q ? k_q : 2'(n);
            assign mac_c[n*COEFF_W +: COEFF_W] = (state_q == ST_CALC) ?
                                                 COEFF_W'(c_rom[{w_row, w_col}]) : '0;
        end
    endgenerate

    generate
        if (SHIFT == 0) begin : g_pass
            assign w_round = mac_y;
        end else begin : g_round
            localparam logic [OUT_W:0] c_half = (OUT_W+1)'(1) << (SHIFT - 1);
            logic signed [OUT_W:0] w_sum;
            // One guard bit keeps the rounding add from overflowing.
            assign w_sum   = $signed({mac_y[OUT_W-1], mac_y} + c_half);
            assign w_round = OUT_W'(w_sum >>> SHIFT);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        inv_d   = inv_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && ready_q) begin
                    x_d     = in_x;
                    inv_d   = in_inv;
                    k_d     = 2'd0;
                    state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                y_d     = w_round;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (k_q == 2'd3) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = ST_CALC;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Handshake outputs are registered from the next state, so they
        // line up with the state they describe.
        valid_d = (state_d == ST_OUT);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        last_d  = (state_d == ST_OUT) && (k_d == 2'd3);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= 2'd0;
            x_q     <= '0;
            inv_q   <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            inv_q   <= inv_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_y     = y_q;
    assign out_idx   = k_q;
    assign out_last  = last_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
